lcd_text_writer: RTL and testbench

- Parametrised HD44780 text writer in 4-bit mode, successor to the fixed two-line, 16-character sender.
- Snapshots a flat text buffer of NUM_LINES x LINE_LENGTH characters on a start request.
- Writes only the lines selected by a mask, each preceded by a DDRAM set-address command, with an optional leading clear-display.
- Contains its own nibble/E-pulse timing engine, so no separate transfer block is needed. Sits between the application text source and the LCD pins.

---
 rtl/lcd_text_writer.sv | 194 +++++++++++++++++++
 tb/tb_lcd_text_writer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_writer.sv
// HD44780 4-bit text writer: snapshots a text buffer on start and sends an optional clear
// plus, for each selected line, a DDRAM address command followed by that line's characters.
module lcd_text_writer #(
    parameter int          NUM_LINES   = 2,
    parameter int          LINE_LENGTH = 16,
    parameter int          CLK_FREQ_HZ = 50000000,
    parameter logic [31:0] LINE_ADDR   = {8'h54, 8'h14, 8'h40, 8'h00}
) (
    input  logic                                CLK,
    input  logic                                RESET_N,
    input  logic                                start,
    input  logic                                clear_first,
    input  logic [NUM_LINES-1:0]                line_mask,
    input  logic [8*NUM_LINES*LINE_LENGTH-1:0]  text,
    output logic                                busy,
    output logic                                done,
    output logic [3:0]                          LCD_D,
    output logic                                LCD_RS,
    output logic                                LCD_E,
    output logic                                LCD_RW
);

    localparam int MHZ    = CLK_FREQ_HZ / 1000000;
    localparam int T_SU   = (CLK_FREQ_HZ / 10000000 > 1) ? CLK_FREQ_HZ / 10000000 : 1;
    localparam int T_E    = (CLK_FREQ_HZ / 2000000 > 1) ? CLK_FREQ_HZ / 2000000 : 1;
    localparam int T_GAP  = (CLK_FREQ_HZ / 1000000 > 1) ? CLK_FREQ_HZ / 1000000 : 1;
    localparam int T_BYTE = (53 * MHZ > 1) ? 53 * MHZ : 1;
    localparam int T_CLR  = (1640 * MHZ > 1) ? 1640 * MHZ : 1;
    localparam int CW     = $clog2(T_CLR + 1);
    localparam int LW     = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int CHW    = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
    localparam int TW     = 8 * NUM_LINES * LINE_LENGTH;

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP_HI, S_PULSE_HI, S_GAP, S_SETUP_LO, S_PULSE_LO, S_WAIT, S_EVAL, S_DONE
    } state_t;

    typedef enum logic [1:0] {K_CLR, K_ADDR, K_DATA} kind_t;

    state_t                 state_q, state_d;
    kind_t                  kind_q, kind_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [LW-1:0]          line_q, line_d;
    logic [CHW-1:0]         char_q, char_d;
    logic [TW-1:0]          text_q, text_d;
    logic [NUM_LINES-1:0]   mask_q, mask_d;

    logic                   first_valid, nxt_valid, hi_phase;
    kind_t                  first_kind, nxt_kind;
    logic [LW-1:0]          first_line, nxt_line;
    logic [CHW-1:0]         nxt_char;
    logic [31:0]            char_idx;
    logic [7:0]             byte_cur;

    // First byte is chosen from the start-time inputs so its setup begins right after accept.
    always_comb begin
        first_valid = clear_first;
        first_kind  = K_CLR;
        first_line  = '0;
        if (!clear_first) begin
            for (int unsigned l = 0; l < NUM_LINES; l++) begin
                if (!first_valid && line_mask[l]) begin
                    first_valid = 1'b1;
                    first_kind  = K_ADDR;
                    first_line  = LW'(l);
                end
            end
        end
    end

    always_comb begin
        nxt_valid = 1'b0;
        nxt_kind  = K_DATA;
        nxt_line  = line_q;
        nxt_char  = '0;
        if (kind_q == K_ADDR) begin
            nxt_valid = 1'b1;
        end else if (kind_q == K_DATA && char_q != CHW'(LINE_LENGTH - 1)) begin
            nxt_valid = 1'b1;
            nxt_char  = char_q + 1'b1;
        end else begin
            for (int unsigned l = 0; l < NUM_LINES; l++) begin
                if (!nxt_valid && mask_q[l] && (kind_q == K_CLR || LW'(l) > line_q)) begin
                    nxt_valid = 1'b1;
                    nxt_kind  = K_ADDR;
                    nxt_line  = LW'(l);
                end
            end
        end
    end

    assign char_idx = 32'(line_q) * 32'(LINE_LENGTH) + 32'(char_q);

    always_comb begin
        case (kind_q)
            K_CLR:   byte_cur = 8'h01;
            K_ADDR:  byte_cur = 8'h80 | 8'(LINE_ADDR >> (32'(line_q) * 8));
            default: byte_cur = 8'(text_q >> (char_idx * 8));
        endcase
    end

    assign hi_phase = (state_q == S_SETUP_HI) || (state_q == S_PULSE_HI) || (state_q == S_GAP);
    assign LCD_RW   = 1'b0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        kind_d  = kind_q;
        line_d  = line_q;
        char_d  = char_q;
        text_d  = text_q;
        mask_d  = mask_q;
        busy    = 1'b0;
        done    = 1'b0;
        LCD_E   = 1'b0;
        LCD_RS  = 1'b0;
        LCD_D   = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                done = (state_q == S_DONE);
                if (state_q == S_DONE) state_d = S_IDLE;
                if (start) begin
                    text_d = text;
                    mask_d = line_mask;
                    kind_d = first_kind;
                    line_d = first_line;
                    char_d = '0;
                    if (first_valid) begin
                        state_d = S_SETUP_HI;
                        cnt_d   = CW'(T_SU - 1);
                    end else begin
                        state_d = S_EVAL;
                    end
                end
            end
            S_EVAL: begin
                busy    = 1'b1;
                state_d = S_DONE;
            end
            default: begin
                busy   = 1'b1;
                LCD_RS = (kind_q == K_DATA);
                LCD_D  = hi_phase ? byte_cur[7:4] : byte_cur[3:0];
                LCD_E  = (state_q == S_PULSE_HI) || (state_q == S_PULSE_LO);
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    case (state_q)
                        S_SETUP_HI: begin state_d = S_PULSE_HI; cnt_d = CW'(T_E - 1);   end
                        S_PULSE_HI: begin state_d = S_GAP;      cnt_d = CW'(T_GAP - 1); end
                        S_GAP:      begin state_d = S_SETUP_LO; cnt_d = CW'(T_SU - 1);  end
                        S_SETUP_LO: begin state_d = S_PULSE_LO; cnt_d = CW'(T_E - 1);   end
                        S_PULSE_LO: begin
                            state_d = S_WAIT;
                            cnt_d   = (kind_q == K_CLR) ? CW'(T_CLR - 1) : CW'(T_BYTE - 1);
                        end
                        default: begin
                            if (nxt_valid) begin
                                state_d = S_SETUP_HI;
                                cnt_d   = CW'(T_SU - 1);
                                kind_d  = nxt_kind;
                                line_d  = nxt_line;
                                char_d  = nxt_char;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            kind_q  <= K_CLR;
            line_q  <= '0;
            char_q  <= '0;
            text_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
            line_q  <= line_d;
            char_q  <= char_d;
            text_q  <= text_d;
            mask_q  <= mask_d;
        end
    end

endmodule

// File: tb/tb_lcd_text_writer.sv
// Bench for lcd_text_writer: a 2x4 display at 10 MHz and a 4x20 display at 1 MHz,
// decoding the nibble bus back into bytes and comparing against hand-computed sequences.
module tb_lcd_text_writer;

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_chk  = 0;

    // DUT A: 2 lines x 4 chars, 10 MHz
    logic        a_start = 1'b0, a_clr = 1'b0;
    logic [1:0]  a_mask = '0;
    logic [63:0] a_text = '0;
    logic        a_busy, a_done, a_RS, a_E, a_RW;
    logic [3:0]  a_D;

    lcd_text_writer #(.NUM_LINES(2), .LINE_LENGTH(4), .CLK_FREQ_HZ(10000000)) dut_a (
        .CLK(CLK), .RESET_N(rst_n), .start(a_start), .clear_first(a_clr), .line_mask(a_mask),
        .text(a_text), .busy(a_busy), .done(a_done), .LCD_D(a_D), .LCD_RS(a_RS), .LCD_E(a_E),
        .LCD_RW(a_RW)
    );

    // DUT B: 4 lines x 20 chars, 1 MHz
    logic         b_start = 1'b0, b_clr = 1'b0;
    logic [3:0]   b_mask = '0;
    logic [639:0] b_text = '0;
    logic         b_busy, b_done, b_RS, b_E, b_RW;
    logic [3:0]   b_D;

    lcd_text_writer #(.NUM_LINES(4), .LINE_LENGTH(20), .CLK_FREQ_HZ(1000000)) dut_b (
        .CLK(CLK), .RESET_N(rst_n), .start(b_start), .clear_first(b_clr), .line_mask(b_mask),
        .text(b_text), .busy(b_busy), .done(b_done), .LCD_D(b_D), .LCD_RS(b_RS), .LCD_E(b_E),
        .LCD_RW(b_RW)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Bus decoders: a byte is the nibble latched at two successive E rises, RS from the low one.
    logic [8:0] a_q[$];
    logic [8:0] b_q[$];
    logic       a_e_prev = 1'b0, a_half = 1'b0;
    logic [3:0] a_hi = '0;
    logic       b_e_prev = 1'b0, b_half = 1'b0, b_rs_prev = 1'b0;
    logic [3:0] b_hi = '0, b_d_prev = '0;

    always @(negedge CLK) begin
        a_e_prev <= a_E;
        if (!rst_n) a_half <= 1'b0;
        else if (a_E && !a_e_prev) begin
            if (!a_half) begin a_hi <= a_D; a_half <= 1'b1; end
            else begin a_q.push_back({a_RS, a_hi, a_D}); a_half <= 1'b0; end
        end
    end

    always @(negedge CLK) begin
        b_e_prev  <= b_E;
        b_rs_prev <= b_RS;
        b_d_prev  <= b_D;
        if (rst_n && b_E != b_e_prev)
            check("b_stable_on_E_edge", {59'd0, b_RS, b_D}, {59'd0, b_rs_prev, b_d_prev});
        if (!rst_n) b_half <= 1'b0;
        else if (b_E && !b_e_prev) begin
            if (!b_half) begin b_hi <= b_D; b_half <= 1'b1; end
            else begin b_q.push_back({b_RS, b_hi, b_D}); b_half <= 1'b0; end
        end
    end

    task automatic run_a(input logic imm, input logic clr, input logic [1:0] mask,
                         input logic [63:0] txt, input int limit, input int poke_at,
                         output int lat, output int busy_c);
        int cyc;
        if (!imm) begin @(posedge CLK); #1; end
        a_start = 1'b1; a_clr = clr; a_mask = mask; a_text = txt;
        @(posedge CLK); #1;
        a_start = 1'b0; cyc = 1; lat = -1; busy_c = 0;
        while (cyc <= limit) begin
            if (a_done) begin lat = cyc; break; end
            if (a_busy) busy_c++;
            if (cyc == poke_at) begin
                a_start = 1'b1; a_clr = 1'b1; a_mask = 2'b11; a_text = ~txt;
            end else begin
                a_start = 1'b0;
            end
            @(posedge CLK); #1; cyc++;
        end
        a_start = 1'b0;
    endtask

    typedef struct {
        string            name;
        logic             clr;
        logic [1:0]       mask;
        logic [63:0]      txt;
        int               n;
        logic [9:0][8:0]  exp;
        int               lat;
    } vec_t;

    localparam logic [63:0] T1 = 64'h5A59_5857_4443_4241;  // line0 "ABCD", line1 "WXYZ"
    localparam logic [63:0] T2 = 64'h3433_3231_6463_6261;  // line0 "abcd", line1 "1234"

    initial begin
        vec_t       vt[5];
        int         lat, bc, base, cyc, extra, idx;
        logic [7:0] adr[4];
        logic [8:0] b_exp[84];
        logic [8:0] got;

        vt[0].name = "mask01"; vt[0].clr = 1'b0; vt[0].mask = 2'b01; vt[0].txt = T1;
        vt[0].n = 5; vt[0].lat = 5*552 + 1; vt[0].exp = '0;
        vt[0].exp[0] = 9'h080; vt[0].exp[1] = 9'h141; vt[0].exp[2] = 9'h142;
        vt[0].exp[3] = 9'h143; vt[0].exp[4] = 9'h144;

        vt[1].name = "clr_mask10"; vt[1].clr = 1'b1; vt[1].mask = 2'b10; vt[1].txt = T1;
        vt[1].n = 6; vt[1].lat = 16422 + 5*552 + 1; vt[1].exp = '0;
        vt[1].exp[0] = 9'h001; vt[1].exp[1] = 9'h0C0; vt[1].exp[2] = 9'h157;
        vt[1].exp[3] = 9'h158; vt[1].exp[4] = 9'h159; vt[1].exp[5] = 9'h15A;

        vt[2].name = "empty"; vt[2].clr = 1'b0; vt[2].mask = 2'b00; vt[2].txt = T1;
        vt[2].n = 0; vt[2].lat = 2; vt[2].exp = '0;

        vt[3].name = "mask11"; vt[3].clr = 1'b0; vt[3].mask = 2'b11; vt[3].txt = T2;
        vt[3].n = 10; vt[3].lat = 10*552 + 1; vt[3].exp = '0;
        vt[3].exp[0] = 9'h080; vt[3].exp[1] = 9'h161; vt[3].exp[2] = 9'h162;
        vt[3].exp[3] = 9'h163; vt[3].exp[4] = 9'h164; vt[3].exp[5] = 9'h0C0;
        vt[3].exp[6] = 9'h131; vt[3].exp[7] = 9'h132; vt[3].exp[8] = 9'h133;
        vt[3].exp[9] = 9'h134;

        vt[4].name = "clear_only"; vt[4].clr = 1'b1; vt[4].mask = 2'b00; vt[4].txt = T2;
        vt[4].n = 1; vt[4].lat = 16422 + 1; vt[4].exp = '0;
        vt[4].exp[0] = 9'h001;

        repeat (3) @(posedge CLK);
        #1;
        check("reset_a", {58'd0, a_busy, a_done, a_E, a_RS, a_RW, (a_D != 4'd0)}, 64'd0);
        check("reset_b", {58'd0, b_busy, b_done, b_E, b_RS, b_RW, (b_D != 4'd0)}, 64'd0);
        @(negedge CLK);
        rst_n = 1'b1;

        // Vectors are chained: each start is raised in the previous request's done cycle.
        for (int i = 0; i < 5; i++) begin
            base = a_q.size();
            run_a(i > 0, vt[i].clr, vt[i].mask, vt[i].txt, vt[i].lat + 50, -1, lat, bc);
            check($sformatf("%s latency", vt[i].name), 64'(lat), 64'(vt[i].lat));
            check($sformatf("%s busy_cycles", vt[i].name), 64'(bc), 64'(vt[i].lat - 1));
            check($sformatf("%s busy_in_done", vt[i].name), {63'd0, a_busy}, 64'd0);
            check($sformatf("%s byte_count", vt[i].name), 64'(a_q.size() - base), 64'(vt[i].n));
            for (int j = 0; j < vt[i].n; j++) begin
                got = (base + j < a_q.size()) ? a_q[base + j] : 9'bx;
                check($sformatf("%s byte%0d", vt[i].name, j), {55'd0, got}, {55'd0, vt[i].exp[j]});
            end
        end

        // Text change and a second start while busy: snapshot wins, single done.
        base = a_q.size();
        run_a(1'b0, 1'b0, 2'b01, T1, 2761 + 50, 700, lat, bc);
        check("snap latency", 64'(lat), 64'(2761));
        check("snap byte_count", 64'(a_q.size() - base), 64'd5);
        for (int j = 0; j < 5; j++) begin
            got = (base + j < a_q.size()) ? a_q[base + j] : 9'bx;
            check($sformatf("snap byte%0d", j), {55'd0, got}, {55'd0, vt[0].exp[j]});
        end
        extra = 0;
        for (int k = 0; k < 600; k++) begin
            @(posedge CLK); #1;
            if (a_done || a_busy) extra++;
        end
        check("snap no_second_request", 64'(extra), 64'd0);

        // Reset while E is high on the third byte.
        base = a_q.size();
        @(posedge CLK); #1;
        a_start = 1'b1; a_clr = 1'b0; a_mask = 2'b01; a_text = T1;
        @(posedge CLK); #1;
        a_start = 1'b0;
        repeat (1106) @(posedge CLK);
        #1;
        check("pre_reset E/RS/D", {58'd0, a_E, a_RS, a_D}, {58'd0, 1'b1, 1'b1, 4'h4});
        rst_n = 1'b0;
        #1;
        check("reset_drop", {57'd0, a_E, a_RS, a_D, a_busy, a_done}, 64'd0);
        check("reset byte_count", 64'(a_q.size() - base), 64'd2);
        extra = 0;
        repeat (3) begin
            @(negedge CLK);
            if (a_done) extra++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge CLK); #1;
            if (a_done || a_busy) extra++;
        end
        check("reset no_done", 64'(extra), 64'd0);
        base = a_q.size();
        run_a(1'b0, 1'b0, 2'b01, T1, 2761 + 50, -1, lat, bc);
        check("post_reset latency", 64'(lat), 64'(2761));
        check("post_reset byte_count", 64'(a_q.size() - base), 64'd5);
        for (int j = 0; j < 5; j++) begin
            got = (base + j < a_q.size()) ? a_q[base + j] : 9'bx;
            check($sformatf("post_reset byte%0d", j), {55'd0, got}, {55'd0, vt[0].exp[j]});
        end

        // 4x20 display, all lines: per byte 1+1+1+1+1+53 = 58 cycles.
        for (int k = 79; k >= 0; k--) b_text = {b_text[631:0], 8'(48 + k)};
        adr[0] = 8'h00; adr[1] = 8'h40; adr[2] = 8'h14; adr[3] = 8'h54;
        idx = 0;
        for (int l = 0; l < 4; l++) begin
            b_exp[idx] = {1'b0, 8'h80 | adr[l]};
            idx++;
            for (int c = 0; c < 20; c++) begin
                b_exp[idx] = {1'b1, 8'(48 + l*20 + c)};
                idx++;
            end
        end
        base = b_q.size();
        @(posedge CLK); #1;
        b_start = 1'b1; b_clr = 1'b0; b_mask = 4'hF;
        @(posedge CLK); #1;
        b_start = 1'b0; cyc = 1; lat = -1;
        while (cyc <= 5000) begin
            if (b_done) begin lat = cyc; break; end
            @(posedge CLK); #1; cyc++;
        end
        check("b latency", 64'(lat), 64'(84*58 + 1));
        check("b byte_count", 64'(b_q.size() - base), 64'd84);
        for (int j = 0; j < 84; j++) begin
            got = (base + j < b_q.size()) ? b_q[base + j] : 9'bx;
            check($sformatf("b byte%0d", j), {55'd0, got}, {55'd0, b_exp[j]});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
